// File: rtl/npc_ctrl_if.sv
// Handshake, decoder-flag and status bundle between npc_ctrl and the fetch/LSU/decoder side.
// master = the sequencer, slave = the datapath and bus units it drives.
interface npc_ctrl_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic        ifu_resp_valid;
  logic        inst_latch;
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_is_ebreak;
  logic        dec_rd_wen;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic        lsu_resp_valid;
  logic        rf_wen;
  logic        pc_wen;
  logic        stop_sim;
  logic        bus_err;
  logic [2:0]  state;
  logic [63:0] perf_cycle;
  logic [63:0] perf_instret;

  modport master (
    output ifu_req_valid, inst_latch, lsu_req_valid, rf_wen, pc_wen,
           stop_sim, bus_err, state, perf_cycle, perf_instret,
    input  ifu_req_ready, ifu_resp_valid, dec_is_load, dec_is_store,
           dec_is_ebreak, dec_rd_wen, lsu_req_ready, lsu_resp_valid
  );

  modport slave (
    input  ifu_req_valid, inst_latch, lsu_req_valid, rf_wen, pc_wen,
           stop_sim, bus_err, state, perf_cycle, perf_instret,
    output ifu_req_ready, ifu_resp_valid, dec_is_load, dec_is_store,
           dec_is_ebreak, dec_rd_wen, lsu_req_ready, lsu_resp_valid
  );
endinterface

// File: rtl/npc_ctrl.sv
// Multi-cycle Moore sequencer for the NPC core: fetch -> decode -> memory -> writeback, with bus timeout.
// Define NPC_CTRL_PERF_EN to build the 64-bit perf_cycle / perf_instret counters; otherwise they read 0.
module npc_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  npc_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH_REQ  = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    MEM_REQ    = 3'd3,
    MEM_WAIT   = 3'd4,
    WB         = 3'd5,
    HALT       = 3'd6
  } state_e;

  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [TO_W:0]   to_cnt_inc;
  logic            ld_q, ld_d;
  logic            st_q, st_d;
  logic            wen_q, wen_d;
  logic            bus_err_q, bus_err_d;
  logic            wait_state;
  logic            advance;
  logic            timed_out;

  always_comb begin
    state_d    = state_q;
    ld_d       = ld_q;
    st_d       = st_q;
    wen_d      = wen_q;
    bus_err_d  = bus_err_q;
    advance    = 1'b0;
    wait_state = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                 (state_q == MEM_REQ)   || (state_q == MEM_WAIT);

    case (state_q)
      FETCH_REQ: begin
        if (bus.ifu_req_ready) begin
          state_d = FETCH_WAIT;
          advance = 1'b1;
        end
      end
      FETCH_WAIT: begin
        if (bus.ifu_resp_valid) begin
          state_d = DECODE;
          advance = 1'b1;
        end
      end
      DECODE: begin
        // A load+store combination is folded into a plain load here.
        ld_d  = bus.dec_is_load;
        st_d  = bus.dec_is_store & ~bus.dec_is_load;
        wen_d = bus.dec_rd_wen;
        if (bus.dec_is_ebreak) begin
          state_d = HALT;
        end else if (bus.dec_is_load || bus.dec_is_store) begin
          state_d = MEM_REQ;
        end else begin
          state_d = WB;
        end
      end
      MEM_REQ: begin
        if (bus.lsu_req_ready) begin
          state_d = MEM_WAIT;
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.lsu_resp_valid) begin
          state_d = WB;
          advance = 1'b1;
        end
      end
      WB: begin
        state_d = FETCH_REQ;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d   = HALT;
        bus_err_d = 1'b1;
      end
    endcase

    // The count reaching TIMEOUT this cycle only errors if no handshake advanced the state.
    to_cnt_inc = {1'b0, to_cnt_q} + {{TO_W{1'b0}}, 1'b1};
    timed_out  = (TIMEOUT != 0) && wait_state && !advance && (to_cnt_inc == TO_LIM);
    if (timed_out) begin
      state_d   = HALT;
      bus_err_d = 1'b1;
    end

    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (wait_state) begin
      to_cnt_d = to_cnt_inc[TO_W-1:0];
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_REQ;
      to_cnt_q  <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      wen_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      ld_q      <= ld_d;
      st_q      <= st_d;
      wen_q     <= wen_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Every strobe and level is forced low for the whole reset cycle, not just after the edge.
  assign bus.ifu_req_valid = ~rst & (state_q == FETCH_REQ);
  assign bus.inst_latch    = ~rst & (state_q == FETCH_WAIT) & bus.ifu_resp_valid;
  assign bus.lsu_req_valid = ~rst & (state_q == MEM_REQ);
  assign bus.pc_wen        = ~rst & (state_q == WB);
  assign bus.rf_wen        = ~rst & (state_q == WB) & wen_q & (ld_q | ~st_q);
  assign bus.stop_sim      = ~rst & (state_q == HALT);
  assign bus.bus_err       = ~rst & bus_err_q;
  assign bus.state         = state_q;

`ifdef NPC_CTRL_PERF_EN
  logic [63:0] perf_cycle_q, perf_cycle_d;
  logic [63:0] perf_instret_q, perf_instret_d;

  always_comb begin
    perf_cycle_d   = perf_cycle_q + ((state_q != HALT) ? 64'd1 : 64'd0);
    perf_instret_d = perf_instret_q + ((state_q == WB) ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycle_q   <= '0;
      perf_instret_q <= '0;
    end else begin
      perf_cycle_q   <= perf_cycle_d;
      perf_instret_q <= perf_instret_d;
    end
  end

  assign bus.perf_cycle   = perf_cycle_q;
  assign bus.perf_instret = perf_instret_q;
`else
  assign bus.perf_cycle   = '0;
  assign bus.perf_instret = '0;
`endif

endmodule

// File: tb/tb_npc_ctrl.sv
// Bench for npc_ctrl: a bus agent feeds an instruction program to one instance and scoreboards
// each retirement/halt; a second instance built with TIMEOUT=4 exercises the timeout boundary.
`timescale 1ns/1ps
module tb_npc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  npc_ctrl_if bus_a ();
  npc_ctrl_if bus_b ();

  npc_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  npc_ctrl #(.TIMEOUT(4), .TO_W(8)) u_dut_to (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

`ifdef NPC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed { logic ld; logic st; logic eb; logic wen; } inst_t;
  typedef struct packed { logic halt; logic rf; } exp_t;

  localparam inst_t ALU_W  = 4'b0001;
  localparam inst_t ALU_N  = 4'b0000;
  localparam inst_t ST_W   = 4'b0101;
  localparam inst_t LD_W   = 4'b1001;
  localparam inst_t LDST_W = 4'b1101;
  localparam inst_t EB_LD  = 4'b1011;

  int     total = 0;
  int     bad   = 0;
  longint cyc   = 0;

  inst_t  prog[$];
  exp_t   sb[$];
  longint wb_cyc_q[$];
  int     lsu_len_q[$];
  int     lsu_hold  = 5;
  int     n_retired = 0;
  int     eb_lsu    = 0;
  longint acc_cyc   = 0;
  longint halt_lat  = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Bus agent for instance A: samples outputs and drives inputs on the falling edge.
  initial begin : agent_a
    inst_t cur;
    exp_t  e;
    logic  fetch_fire, mem_fire, halt_seen;
    int    lsu_wait;
    cur = '0; fetch_fire = 1'b0; mem_fire = 1'b0; halt_seen = 1'b0; lsu_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_a.ifu_req_ready = 1'b0; bus_a.ifu_resp_valid = 1'b0;
        bus_a.lsu_req_ready = 1'b0; bus_a.lsu_resp_valid = 1'b0;
        bus_a.dec_is_load = 1'b0; bus_a.dec_is_store = 1'b0;
        bus_a.dec_is_ebreak = 1'b0; bus_a.dec_rd_wen = 1'b0;
        fetch_fire = 1'b0; mem_fire = 1'b0; halt_seen = 1'b0; lsu_wait = 0;
        cur = '0;
        sb.delete();
        continue;
      end

      if (bus_a.pc_wen) begin
        wb_cyc_q.push_back(cyc);
        n_retired++;
        if (sb.size() == 0) begin
          check_val("wb_without_issue", 64'(bus_a.pc_wen), 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("wb_instead_of_halt", 64'(bus_a.pc_wen), 64'(!e.halt));
          if (!e.halt) check_val("rf_wen", 64'(bus_a.rf_wen), 64'(e.rf));
          $display("retire #%0d cyc=%0d rf_wen=%0b exp_rf=%0b", n_retired, cyc, bus_a.rf_wen, e.rf);
        end
      end
      if (bus_a.stop_sim && !halt_seen) begin
        halt_seen = 1'b1;
        halt_lat  = cyc - acc_cyc;
        if (sb.size() == 0) begin
          check_val("halt_without_issue", 64'(bus_a.stop_sim), 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("unexpected_halt", 64'(bus_a.stop_sim), 64'(e.halt));
          $display("halt cyc=%0d bus_err=%0b", cyc, bus_a.bus_err);
        end
      end
      if (bus_a.lsu_req_valid && cur.eb) eb_lsu++;

      // Responses come exactly one cycle after the request was accepted.
      bus_a.ifu_resp_valid = fetch_fire;
      bus_a.lsu_resp_valid = mem_fire;
      if (fetch_fire) begin
        cur = (prog.size() != 0) ? prog.pop_front() : ALU_W;
        bus_a.dec_is_load   = cur.ld;
        bus_a.dec_is_store  = cur.st;
        bus_a.dec_is_ebreak = cur.eb;
        bus_a.dec_rd_wen    = cur.wen;
        e.halt = cur.eb;
        e.rf   = cur.wen && !(cur.st && !cur.ld);
        sb.push_back(e);
        $display("issue cyc=%0d ld=%0b st=%0b eb=%0b wen=%0b", cyc, cur.ld, cur.st, cur.eb, cur.wen);
      end

      bus_a.ifu_req_ready = 1'b1;
      if (bus_a.lsu_req_valid) begin
        lsu_wait++;
        bus_a.lsu_req_ready = (lsu_wait >= lsu_hold);
      end else begin
        lsu_wait = 0;
        bus_a.lsu_req_ready = 1'b0;
      end
      fetch_fire = bus_a.ifu_req_valid;
      if (fetch_fire) acc_cyc = cyc;
      mem_fire = bus_a.lsu_req_valid && bus_a.lsu_req_ready;
      if (mem_fire) begin
        lsu_len_q.push_back(lsu_wait);
        lsu_wait = 0;
      end
    end
  end

  initial begin : main
    longint c0;
    int     n;
    int     cnt;
    bus_b.ifu_req_ready = 1'b0; bus_b.ifu_resp_valid = 1'b0;
    bus_b.lsu_req_ready = 1'b0; bus_b.lsu_resp_valid = 1'b0;
    bus_b.dec_is_load = 1'b0; bus_b.dec_is_store = 1'b0;
    bus_b.dec_is_ebreak = 1'b0; bus_b.dec_rd_wen = 1'b0;
    prog = {ALU_W, ALU_W, ALU_W, ST_W, LD_W, LDST_W, ALU_N, EB_LD};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_state", 64'(bus_a.state), 64'd0);
    check_val("rst_ifu_req_valid", 64'(bus_a.ifu_req_valid), 64'd0);
    check_val("rst_stop_sim", 64'(bus_a.stop_sim), 64'd0);
    check_val("rst_bus_err", 64'(bus_a.bus_err), 64'd0);
    check_val("rst_perf_cycle", bus_a.perf_cycle, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    c0 = cyc;
    @(negedge clk);
    check_val("first_req", 64'(bus_a.ifu_req_valid), 64'd1);

    // Zero-wait ALU stream: WB every 4 cycles, 3 retired after 12 cycles
    repeat (12) @(posedge clk);
    #1;
    check_val("instret_12", bus_a.perf_instret, PERF ? 64'd3 : 64'd0);
    check_val("cycle_12", bus_a.perf_cycle, PERF ? 64'd12 : 64'd0);
    check_val("wb_count_12", 64'(wb_cyc_q.size()), 64'd3);
    if (wb_cyc_q.size() >= 3) begin
      check_val("alu_latency", 64'(wb_cyc_q[0] - c0), 64'd3);
      check_val("wb_gap_1", 64'(wb_cyc_q[1] - wb_cyc_q[0]), 64'd4);
      check_val("wb_gap_2", 64'(wb_cyc_q[2] - wb_cyc_q[1]), 64'd4);
    end

    // Store, load, load+store, ALU without rd, then ebreak+load halts
    n = 0;
    while (!bus_a.stop_sim && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_val("halt_reached", 64'(bus_a.stop_sim), 64'd1);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus_a.stop_sim) cnt++;
    end
    check_val("halt_persists", 64'(cnt), 64'd100);
    check_val("halt_bus_err", 64'(bus_a.bus_err), 64'd0);
    check_val("perf_cycle_frozen", bus_a.perf_cycle, PERF ? 64'd49 : 64'd0);
    check_val("perf_instret_total", bus_a.perf_instret, PERF ? 64'd7 : 64'd0);
    check_val("retired_total", 64'(n_retired), 64'd7);
    check_val("ebreak_latency", 64'(halt_lat), 64'd3);
    check_val("ebreak_no_lsu", 64'(eb_lsu), 64'd0);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    check_val("lsu_req_count", 64'(lsu_len_q.size()), 64'd3);
    for (int i = 0; i < lsu_len_q.size(); i++) begin
      check_val("lsu_valid_hold", 64'(lsu_len_q[i]), 64'd5);
    end

    // Leave HALT through reset, then pulse reset while in MEM_WAIT
    prog = {LD_W, ALU_W};
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (bus_a.state != 3'd4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_val("reach_mem_wait", 64'(bus_a.state), 64'd4);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_lsu_valid", 64'(bus_a.lsu_req_valid), 64'd0);
    check_val("rst_mid_ifu_valid", 64'(bus_a.ifu_req_valid), 64'd0);
    check_val("rst_mid_pc_wen", 64'(bus_a.pc_wen), 64'd0);
    check_val("rst_mid_rf_wen", 64'(bus_a.rf_wen), 64'd0);
    check_val("rst_mid_inst_latch", 64'(bus_a.inst_latch), 64'd0);
    check_val("rst_mid_stop_sim", 64'(bus_a.stop_sim), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    check_val("rst_mid_state", 64'(bus_a.state), 64'd0);
    check_val("rst_mid_perf_cycle", bus_a.perf_cycle, 64'd0);
    check_val("rst_mid_perf_instret", bus_a.perf_instret, 64'd0);
    @(negedge clk);
    check_val("rst_mid_req_after", 64'(bus_a.ifu_req_valid), 64'd1);
    cnt = n_retired;
    n = 0;
    while (n_retired == cnt && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_val("retire_after_rst", 64'(n_retired - cnt), 64'd1);

    // TIMEOUT=4: no fetch response ever arrives
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    bus_b.ifu_req_ready = 1'b1;
    @(posedge clk); #1 bus_b.ifu_req_ready = 1'b0;
    #1 check_val("to_in_fetch_wait", 64'(bus_b.state), 64'd1);
    n = 0;
    while (!bus_b.stop_sim && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("to_halt_cycles", 64'(n), 64'd4);
    check_val("to_bus_err", 64'(bus_b.bus_err), 64'd1);
    check_val("to_stop_sim", 64'(bus_b.stop_sim), 64'd1);
    check_val("to_state", 64'(bus_b.state), 64'd6);
    $display("timeout halt after %0d wait cycles bus_err=%0b", n, bus_b.bus_err);

    // TIMEOUT=4: response on the 4th wait cycle wins over the timeout
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
    bus_b.ifu_req_ready = 1'b1;
    @(posedge clk); #1 bus_b.ifu_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus_b.ifu_resp_valid = 1'b1;
    @(negedge clk);
    check_val("to_edge_inst_latch", 64'(bus_b.inst_latch), 64'd1);
    check_val("to_edge_still_wait", 64'(bus_b.state), 64'd1);
    @(posedge clk); #1 bus_b.ifu_resp_valid = 1'b0;
    #1;
    check_val("to_edge_decode", 64'(bus_b.state), 64'd2);
    check_val("to_edge_bus_err", 64'(bus_b.bus_err), 64'd0);
    check_val("to_edge_stop_sim", 64'(bus_b.stop_sim), 64'd0);
    $display("timeout-edge response state=%0d bus_err=%0b", bus_b.state, bus_b.bus_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
